// File: rtl/jk_pkg.sv
// jk_pkg: op codes and FSM state encoding shared by the JK bank controller
package jk_pkg;

    localparam logic [2:0] OP_HOLD   = 3'd0;
    localparam logic [2:0] OP_CLEAR  = 3'd1;
    localparam logic [2:0] OP_SET    = 3'd2;
    localparam logic [2:0] OP_LOAD   = 3'd3;
    localparam logic [2:0] OP_TOGGLE = 3'd4;
    localparam logic [2:0] OP_SHIFT  = 3'd5;
    localparam logic [2:0] OP_COUNT  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/jk_bank_ctrl_if.sv
// jk_bank_ctrl_if: valid/ready command channel from host sequencer to the bank controller
interface jk_bank_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;

    modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/jk_cell.sv
// jk_cell: single JK flip-flop with asynchronous active-low clear
module jk_cell (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_bar
);
    logic q_q, q_d;

    // JK truth table: 00 hold, 01 reset, 10 set, 11 toggle
    always_comb begin
        q_d = (j & ~q_q) | (~k & q_q);
    end

    // storage flop, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q_q <= 1'b0;
        else      q_q <= q_d;
    end

    assign q     = q_q;
    assign q_bar = ~q_q;
endmodule

// File: rtl/jk_bank_ctrl.sv
// jk_bank_ctrl: command FSM translating host ops into per-bit j/k drive for a JK bank
module jk_bank_ctrl
    import jk_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    jk_bank_ctrl_if.slave     cmd,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  q_bar,
    output logic              busy,
    output logic              done
);
    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] j, k, t, src;
    logic             accept, active;

    assign cmd.cmd_ready = (state_q == ST_IDLE);
    assign accept        = cmd.cmd_valid & cmd.cmd_ready;
    assign active        = (state_q == ST_APPLY) | (state_q == ST_RUN);
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);

    // next-state: latch command on accept, count down remaining steps in RUN
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: if (accept) begin
                op_d   = cmd.cmd_op;
                data_d = cmd.cmd_data;
                if (cmd.cmd_op == OP_COUNT) begin
                    rem_d   = cmd.cmd_data;
                    state_d = (cmd.cmd_data != '0) ? ST_RUN : ST_DONE;
                end else begin
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: state_d = ST_DONE;
            ST_RUN: begin
                rem_d   = rem_q - WIDTH'(1);
                state_d = (rem_q == WIDTH'(1)) ? ST_DONE : ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // controller registers, discarded on async reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            data_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
        end
    end

    // per-bit j/k decode; t is the set of bits an increment flips
    always_comb begin
        t   = q ^ (q + WIDTH'(1));
        src = {q[WIDTH-2:0], data_q[0]};
        j   = '0;
        k   = '0;
        if (active) begin
            case (op_q)
                OP_CLEAR:  k = '1;
                OP_SET:    j = '1;
                OP_LOAD:   begin j = data_q; k = ~data_q; end
                OP_TOGGLE: begin j = data_q; k = data_q;  end
                OP_SHIFT:  begin j = src;    k = ~src;    end
                OP_COUNT:  begin j = t;      k = t;       end
                default:   begin j = '0;     k = '0;      end
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk   (clk),
            .rst   (rst),
            .j     (j[i]),
            .k     (k[i]),
            .q     (q[i]),
            .q_bar (q_bar[i])
        );
    end
endmodule

// File: tb/tb_jk_bank_ctrl.sv
// tb_jk_bank_ctrl: directed and random command sequences checked against a behavioural bank model
module tb_jk_bank_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] q, q_bar;
    logic       busy, done;
    logic [3:0] mq;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    jk_bank_ctrl_if #(.WIDTH(4)) bus ();

    jk_bank_ctrl #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .cmd   (bus),
        .q     (q),
        .q_bar (q_bar),
        .busy  (busy),
        .done  (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // what the bank holds after one application of a single-step op
    function automatic logic [3:0] ref_step(input int op, input int d, input int cur);
        int r;
        case (op)
            1:       r = 0;
            2:       r = 15;
            3:       r = d;
            4:       r = cur ^ d;
            5:       r = (cur * 2 + d % 2) % 16;
            default: r = cur;
        endcase
        return 4'(r);
    endfunction

    // issue one command, keep valid high with junk while busy, check every cycle
    task automatic run_cmd(input logic [2:0] op, input logic [3:0] d);
        int n;
        int w;
        w = 0;
        while (bus.cmd_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before_cmd", 32'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        @(negedge clk);
        n = (op == 3'd6) ? int'(d) : 1;
        chk("accept_busy", 32'(busy), 1);
        chk("accept_ready", 32'(bus.cmd_ready), 0);
        chk("accept_q", 32'(q), 32'(mq));
        chk("accept_done", 32'(done), 32'(n == 0));
        for (int s = 1; s <= n; s++) begin
            bus.cmd_op   = 3'($urandom_range(0, 7));
            bus.cmd_data = 4'($urandom_range(0, 15));
            @(negedge clk);
            mq = (op == 3'd6) ? 4'((int'(mq) + 1) % 16) : ref_step(int'(op), int'(d), int'(mq));
            chk("step_q", 32'(q), 32'(mq));
            chk("step_qbar", 32'(q_bar), 32'(4'(~mq)));
            chk("step_done", 32'(done), 32'(s == n));
            chk("step_busy", 32'(busy), 1);
        end
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("end_done", 32'(done), 0);
        chk("end_busy", 32'(busy), 0);
        chk("end_ready", 32'(bus.cmd_ready), 1);
        chk("end_q", 32'(q), 32'(mq));
    endtask

    initial begin
        rst           = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_data  = 4'd0;
        mq            = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_q", 32'(q), 0);
        chk("rst_qbar", 32'(q_bar), 32'hf);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ready", 32'(bus.cmd_ready), 1);
        rst = 1'b1;

        run_cmd(3'd3, 4'b1010);
        chk("plan_load", 32'(q), 32'b1010);
        chk("plan_load_qbar", 32'(q_bar), 32'b0101);

        run_cmd(3'd2, 4'd0);
        chk("plan_set", 32'(q), 32'b1111);
        run_cmd(3'd4, 4'b0110);
        chk("plan_toggle", 32'(q), 32'b1001);
        run_cmd(3'd1, 4'd0);
        chk("plan_clear", 32'(q), 32'b0000);

        run_cmd(3'd3, 4'b0001);
        run_cmd(3'd5, 4'b0001);
        chk("plan_shift1", 32'(q), 32'b0011);
        run_cmd(3'd5, 4'b1110);
        chk("plan_shift0", 32'(q), 32'b0110);

        run_cmd(3'd3, 4'b1110);
        run_cmd(3'd6, 4'd3);
        chk("plan_count_wrap", 32'(q), 32'b0001);

        run_cmd(3'd6, 4'd0);
        chk("plan_count0", 32'(q), 32'b0001);
        run_cmd(3'd7, 4'b1111);
        chk("plan_rsvd", 32'(q), 32'b0001);

        run_cmd(3'd1, 4'd0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd6;
        bus.cmd_data  = 4'd10;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int s = 1; s <= 4; s++) begin
            @(negedge clk);
            chk("midrun_done", 32'(done), 0);
        end
        chk("midrun_q", 32'(q), 32'b0100);
        #2 rst = 1'b0;
        #1;
        chk("async_q", 32'(q), 0);
        chk("async_busy", 32'(busy), 0);
        chk("async_done", 32'(done), 0);
        chk("async_ready", 32'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd3;
        bus.cmd_data  = 4'b1111;
        @(negedge clk);
        chk("held_rst_q", 32'(q), 0);
        chk("held_rst_busy", 32'(busy), 0);
        bus.cmd_valid = 1'b0;
        rst = 1'b1;
        mq  = 4'd0;
        run_cmd(3'd3, 4'b0011);
        chk("post_rst_load", 32'(q), 32'b0011);

        for (int r = 0; r < 40; r++)
            run_cmd(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/jk_bank_ctrl.md
# jk_bank_ctrl

Command-driven controller for a bank of WIDTH JK flip-flops. Accepts one operation at a time over a valid/ready handshake and translates it into per-bit j/k drive for the bank. Supports hold, clear, set, load, toggle, shift, and multi-cycle count. Sits between a host sequencer and the JK storage, and is the only writer of that storage.

## Interface
- WIDTH, 4: number of JK cells in the bank (≥2).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept; equals (state == IDLE).
- cmd_op  in  3  0 HOLD, 1 CLEAR, 2 SET, 3 LOAD, 4 TOGGLE, 5 SHIFT, 6 COUNT, 7 reserved (executes as HOLD).
- cmd_data  in  WIDTH  LOAD value / TOGGLE mask / SHIFT serial-in (bit 0) / COUNT step count; ignored otherwise.
- q  out  WIDTH  bank state.
- q_bar  out  WIDTH  ~q.
- busy  out  1  high in APPLY, RUN, DONE.
- done  out  1  one-cycle pulse when a command completes.

## Operation
- Command accepted on a rising edge with rst high, cmd_valid=1, cmd_ready=1. op/data latched into op_r/data_r. Inputs are ignored while not IDLE.
- Per-bit j/k derived from op_r in APPLY/RUN, and j=k=0 in all other states:
  - HOLD: j=0, k=0.
  - CLEAR: j=0, k=1.
  - SET: j=1, k=0.
  - LOAD: j=data_r, k=~data_r.
  - TOGGLE: j=k=data_r.
  - SHIFT: bit0 gets data_r[0], bit i gets q[i-1]; realised as j=src, k=~src.
  - COUNT: j=k=t, where t[0]=1 and t[i]=&q[i-1:0] (synchronous binary increment).
- FSM states: IDLE, APPLY, RUN, DONE.
  - IDLE → APPLY on accept of a non-COUNT op.
  - IDLE → RUN on accept of COUNT with data≠0; remaining counter loads cmd_data.
  - IDLE → DONE on accept of COUNT with data=0; q unchanged.
  - APPLY → DONE after one edge.
  - RUN: each edge increments q and decrements remaining. Exits to DONE on the edge where remaining goes 1→0.
  - DONE → IDLE unconditionally. done=1 only in DONE.
- Count wrap-around: all-ones + 1 = 0, with no flag. Wrap may occur mid-RUN.
- Reset, async assert at any time including mid-RUN:
  - q=0, state=IDLE, remaining=0, op_r=0, data_r=0, done=0, busy=0.
  - Partial count is discarded and the command is lost (no done pulse).
  - cmd_ready reads 1 during reset but no accept occurs while rst=0.
- Deassertion takes effect at the next edge; the first accept is possible on that edge.

## Timing
- Single-cycle ops:
  - Accept at edge E.
  - q updates at E+1.
  - done high between E+1 and E+2.
  - cmd_ready returns at E+2. Next accept no earlier than E+2 (3-cycle command period).
- COUNT N≥1:
  - q updates at edges E+1 … E+N.
  - done high between E+N and E+N+1.
  - Next accept no earlier than E+N+1.
- COUNT 0: done high between E+1 and E+2, i.e. DONE is entered directly at E+1.
- q, done, busy are registered or derived from registered state; no combinational path from cmd_* to q.
- cmd_ready depends combinationally on state only.

## Structure
- Shared package jk_pkg: op-code localparams (OP_HOLD…OP_COUNT) and FSM state encodings (2-bit).
- Sub-module jk_cell: one JK flip-flop with clk, async active-low rst (q→0), j, k, q, q_bar; standard hold/reset/set/toggle truth table. Instantiated WIDTH times in a generate loop.
- jk_bank_ctrl holds the FSM, op_r/data_r/remaining registers, and the j/k decode.

## Test plan
WIDTH=4 throughout.
- Reset then LOAD 4'b1010 → q=1010 one edge after accept; done pulses once; cmd_ready low 2 cycles; q_bar=0101.
- SET, then TOGGLE mask 4'b0110, then CLEAR → q goes 1111, then 1001, then 0000; each command yields exactly one done pulse.
- Shift sequence:
  - LOAD 0001.
  - SHIFT data[0]=1 → q=0011.
  - SHIFT data[0]=0 → q=0110.
- Count sequence:
  - LOAD 1110.
  - COUNT 3 → q steps 1111, then 0000 (wrap), then 0001 on successive edges.
  - done pulse arrives 3 cycles after accept; busy high for 4 cycles.
- COUNT 0 → q unchanged; done one cycle after accept. Op 7 → q unchanged; done pulses as for HOLD.
- Async reset low mid-COUNT 10 from 0000, after 4 increments (q=0100) → q=0 immediately without a clock edge; no done pulse. After release, LOAD 0011 is accepted on the first edge and completes normally.
